// File: rtl/lap_pkg.sv
// Shared constants for the lap capture buffer: display mode encodings and
// default geometry.
package lap_pkg;

    // Display mode encodings for the mode input
    localparam logic MODE_LIVE = 1'b0;
    localparam logic MODE_HOLD = 1'b1;

    // Default geometry: 16-bit timer value, four lap entries
    localparam int LAP_WIDTH_DEF = 16;
    localparam int LAP_DEPTH_DEF = 4;

endpackage : lap_pkg

// File: rtl/lap_fifo.sv
// Circular lap storage with read/write pointers, occupancy count and
// registered read head.
// Optional feature: define LAP_OVERWRITE_EN so that a write into a full
// buffer (with no pop in the same cycle) replaces the oldest entry.
module lap_fifo
    import lap_pkg::*;
#(
    parameter int WIDTH = LAP_WIDTH_DEF,
    parameter int DEPTH = LAP_DEPTH_DEF,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full_hit
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic             full;
    logic             empty;
    logic             do_pop;
    logic             ovw;
    logic             wr_adv;
    logic             rd_adv;
    logic [AW-1:0]    wr_ptr_n;
    logic [AW-1:0]    rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic [WIDTH-1:0] head_n;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state pointers, occupancy and the value that becomes the read head
    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        do_pop   = rd_en & ~empty;
        ovw      = 1'b0;
`ifdef LAP_OVERWRITE_EN
        ovw      = wr_en & full & ~do_pop;
`endif
        full_hit = wr_en & full & ~do_pop;
        wr_adv   = (wr_en & (~full | do_pop)) | ovw;
        rd_adv   = do_pop | ovw;
        wr_ptr_n = wr_adv ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_n = rd_adv ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_n  = count_q;
        case ({wr_adv, rd_adv})
            2'b10:   count_n = count_q + CW'(1);
            2'b01:   count_n = count_q - CW'(1);
            default: count_n = count_q;
        endcase
        // A write landing on the slot that becomes the head bypasses the array
        head_n = (wr_adv && (wr_ptr_q == rd_ptr_n)) ? wr_data : mem[rd_ptr_n];
    end

    // Pointer, count and read-head registers; clr has priority over traffic
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            count_q  <= count_n;
            rd_valid <= (count_n != '0);
            rd_data  <= head_n;
        end
    end

    // Lap storage array
    // NOTE: the array has no reset; stale entries are never visible because count and pointers are reset.
    always_ff @(posedge clk) begin
        if (wr_adv && !clr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign count = count_q;

endmodule : lap_fifo

// File: rtl/lap_capture_buffer.sv
// Lap capture buffer: detects lap button edges, stores timer snapshots in a
// circular buffer with a valid/ready read port, and drives a live or held
// display value. Optional feature macro: LAP_OVERWRITE_EN (see lap_fifo).
module lap_capture_buffer
    import lap_pkg::*;
#(
    parameter int WIDTH = LAP_WIDTH_DEF,
    parameter int DEPTH = LAP_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       cap,
    input  logic                       mode,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           disp,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    logic cap_q;
    logic cap_ev;
    logic full_hit;

    // Single capture per button press regardless of how long it is held
    assign cap_ev = cap & ~cap_q;

    // Previous button level for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_q <= 1'b0;
        end else begin
            cap_q <= cap;
        end
    end

    // Display: follows the timer in live mode, freezes on the last lap in hold mode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp <= '0;
        end else if (clr) begin
            disp <= '0;
        end else if (mode == MODE_LIVE || cap_ev) begin
            disp <= din;
        end
    end

    // Sticky flag for a capture that found the buffer full with no pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (full_hit) begin
            overflow <= 1'b1;
        end
    end

    lap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .wr_en    (cap_ev),
        .wr_data  (din),
        .rd_en    (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full_hit (full_hit)
    );

endmodule : lap_capture_buffer
